// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared widths, output-stage state enum and decimation helpers
package dsp_pkg;

    localparam int AXIS_TDATA_W = 32;
    localparam int DEC_MAX_W    = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    // A decimation factor of 0 would never wrap the phase counter; treat it as 1.
    function automatic logic [DEC_MAX_W-1:0] clamp_dec(input logic [DEC_MAX_W-1:0] n);
        return (n == '0) ? DEC_MAX_W'(1) : n;
    endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// rtl/axis_skid_reg.sv - registered AXI-Stream slice with a one-entry skid buffer
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_tdata/tvalid/tready  upstream side (payload is opaque, W bits)
//   m_tdata/tvalid/tready  downstream side, driven straight from registers
module axis_skid_reg
    import dsp_pkg::*;
#(
    parameter int W = 37
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] s_tdata,
    input  logic         s_tvalid,
    output logic         s_tready,
    output logic [W-1:0] m_tdata,
    output logic         m_tvalid,
    input  logic         m_tready
);

    skid_state_t  state, state_next;
    logic [W-1:0] out_data, skid_data;
    logic         ready_en;
    logic         in_fire;
    logic         load_out, load_skid, skid_to_out;

    // Upstream is held off during reset and for the first edge after release.
    assign s_tready = ready_en && (state != TWO);
    assign in_fire  = s_tvalid && s_tready;
    assign m_tvalid = (state != EMPTY);
    assign m_tdata  = out_data;

    always_comb begin
        state_next  = state;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    load_out   = 1'b1;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (in_fire && m_tready) begin
                    load_out = 1'b1;             // replace in place, no bubble
                end else if (in_fire) begin
                    load_skid  = 1'b1;
                    state_next = TWO;
                end else if (m_tready) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (m_tready) begin
                    skid_to_out = 1'b1;
                    state_next  = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            ready_en  <= 1'b0;
            out_data  <= '0;
            skid_data <= '0;
        end else begin
            state    <= state_next;
            ready_en <= 1'b1;
            if (load_out) begin
                out_data <= s_tdata;
            end else if (skid_to_out) begin
                out_data <= skid_data;
            end
            if (load_skid) begin
                skid_data <= s_tdata;
            end
        end
    end

endmodule

// File: rtl/fir_decimate.sv
// rtl/fir_decimate.sv - keep-one-in-N decimator for the FIR output stream
//
// Ports:
//   s00_axis_aclk, s00_axis_aresetn  clock, asynchronous active-low reset
//   dec_factor                       decimation factor N (0 acts as 1), latched per packet
//   s00_axis_*                       AXI-Stream slave input
//   m00_axis_*                       AXI-Stream master output (registered, skid-buffered)
//   pkt_count                        completed output packets, wraps at 2^16
module fir_decimate
    import dsp_pkg::*;
#(
    parameter int C_S00_AXIS_TDATA_WIDTH = AXIS_TDATA_W,
    parameter int C_M00_AXIS_TDATA_WIDTH = AXIS_TDATA_W,
    parameter int DEC_W                  = 8
) (
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_aresetn,
    input  logic [DEC_W-1:0]                      dec_factor,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
    input  logic                                  s00_axis_tvalid,
    input  logic                                  s00_axis_tlast,
    output logic                                  s00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                                  m00_axis_tvalid,
    output logic                                  m00_axis_tlast,
    input  logic                                  m00_axis_tready,
    output logic [15:0]                           pkt_count
);

    localparam int DW = C_M00_AXIS_TDATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int PW = DW + SW + 1;

    logic [DEC_W-1:0] phase, nlat, n_eff;
    logic             pkt_start;
    logic             accept, keep;
    logic [PW-1:0]    s_payload, m_payload;

    // The first beat of a packet uses the live dec_factor; later beats use the latched copy.
    assign n_eff  = pkt_start ? DEC_W'(clamp_dec(DEC_MAX_W'(dec_factor))) : nlat;
    assign accept = s00_axis_tvalid && s00_axis_tready;
    assign keep   = (phase == '0) || s00_axis_tlast;

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            phase     <= '0;
            nlat      <= DEC_W'(1);
            pkt_start <= 1'b1;
        end else if (accept) begin
            if (pkt_start) begin
                nlat <= n_eff;
            end
            phase     <= (s00_axis_tlast || (phase == n_eff - DEC_W'(1))) ? '0 : phase + DEC_W'(1);
            pkt_start <= s00_axis_tlast;
        end
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            pkt_count <= '0;
        end else if (m00_axis_tvalid && m00_axis_tready && m00_axis_tlast) begin
            pkt_count <= pkt_count + 16'd1;
        end
    end

    assign s_payload = {s00_axis_tdata, s00_axis_tstrb, s00_axis_tlast};

    // Dropped beats are consumed here without ever reaching the slice.
    axis_skid_reg #(
        .W (PW)
    ) u_out (
        .clk      (s00_axis_aclk),
        .rst_n    (s00_axis_aresetn),
        .s_tdata  (s_payload),
        .s_tvalid (s00_axis_tvalid && keep),
        .s_tready (s00_axis_tready),
        .m_tdata  (m_payload),
        .m_tvalid (m00_axis_tvalid),
        .m_tready (m00_axis_tready)
    );

    assign m00_axis_tdata = m_payload[PW-1 -: DW];
    assign m00_axis_tstrb = m_payload[SW:1];
    assign m00_axis_tlast = m_payload[0];

endmodule

// File: tb/tb_fir_decimate.sv
// tb/tb_fir_decimate.sv - scoreboard bench for fir_decimate with randomized stimulus
module tb_fir_decimate;

    logic        s00_axis_aclk = 1'b0;
    logic        s00_axis_aresetn = 1'b1;
    logic [7:0]  dec_factor = 8'd1;
    logic [31:0] s00_axis_tdata = '0;
    logic [3:0]  s00_axis_tstrb = '0;
    logic        s00_axis_tvalid = 1'b0;
    logic        s00_axis_tlast = 1'b0;
    logic        s00_axis_tready;
    logic [31:0] m00_axis_tdata;
    logic [3:0]  m00_axis_tstrb;
    logic        m00_axis_tvalid;
    logic        m00_axis_tlast;
    logic        m00_axis_tready = 1'b1;
    logic [15:0] pkt_count;

    fir_decimate dut (
        .s00_axis_aclk    (s00_axis_aclk),
        .s00_axis_aresetn (s00_axis_aresetn),
        .dec_factor       (dec_factor),
        .s00_axis_tdata   (s00_axis_tdata),
        .s00_axis_tstrb   (s00_axis_tstrb),
        .s00_axis_tvalid  (s00_axis_tvalid),
        .s00_axis_tlast   (s00_axis_tlast),
        .s00_axis_tready  (s00_axis_tready),
        .m00_axis_tdata   (m00_axis_tdata),
        .m00_axis_tstrb   (m00_axis_tstrb),
        .m00_axis_tvalid  (m00_axis_tvalid),
        .m00_axis_tlast   (m00_axis_tlast),
        .m00_axis_tready  (m00_axis_tready),
        .pkt_count        (pkt_count)
    );

    always #5 s00_axis_aclk = ~s00_axis_aclk;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  s;
        logic        l;
    } beat_t;

    beat_t exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    bit    mon_en = 1'b0;
    bit    chk_rdy = 1'b0;
    int    rdy_mode = 0;
    int    pkts_sent = 0;
    bit    stalled = 1'b0;
    beat_t held;
    beat_t popped;
    int    rcyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: samples on the falling edge, i.e. the values the next rising edge will see.
    always @(negedge s00_axis_aclk) begin
        if (s00_axis_aresetn && mon_en) begin
            if (stalled)
                check("hold_stable", {m00_axis_tvalid, m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast},
                      {1'b1, held});
            if (m00_axis_tvalid && m00_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", {m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast}, 64'hdead);
                end else begin
                    popped = exp_q.pop_front();
                    check("out_beat", {m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast}, popped);
                end
            end
            if (!s00_axis_tready)
                check("tready_low_only_when_full", m00_axis_tvalid, 1);
            if (chk_rdy)
                check("tready_full_rate", s00_axis_tready, 1);
            stalled = m00_axis_tvalid && !m00_axis_tready;
            held    = {m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast};
        end else begin
            stalled = 1'b0;
        end
    end

    // Downstream ready patterns: 0 always, 1 four-cycle windows 1,0,0,1, 2 random, other held low.
    always @(posedge s00_axis_aclk) begin
        #1;
        rcyc++;
        case (rdy_mode)
            0:       m00_axis_tready = 1'b1;
            1:       m00_axis_tready = (((rcyc / 4) % 4) == 0) || (((rcyc / 4) % 4) == 3);
            2:       m00_axis_tready = 1'($urandom_range(0, 1));
            default: m00_axis_tready = 1'b0;
        endcase
    end

    // Called at rising edge + 1; returns at rising edge + 1 after the beat was accepted.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
        int t;
        t = 0;
        s00_axis_tdata  = d;
        s00_axis_tstrb  = s;
        s00_axis_tlast  = l;
        s00_axis_tvalid = 1'b1;
        @(negedge s00_axis_aclk);
        while (!s00_axis_tready && t < 1000) begin
            @(negedge s00_axis_aclk);
            t++;
        end
        if (t >= 1000) check("input_timeout", 0, 1);
        @(posedge s00_axis_aclk);
        #1;
        s00_axis_tvalid = 1'b0;
        s00_axis_tlast  = 1'b0;
    endtask

    // Reference: a packet keeps every beat whose index is a multiple of N, plus its last beat.
    task automatic send_pkt(input int nset, input int len, input logic [31:0] base,
                            input bit randd, input int mid_n, input bit gaps, input bit lat);
        int          ne;
        logic [31:0] d;
        logic [3:0]  s;
        logic        l;
        ne = (nset == 0) ? 1 : nset;
        dec_factor = 8'(nset);
        for (int i = 0; i < len; i++) begin
            d = randd ? $urandom : base + 32'(i);
            s = 4'($urandom_range(0, 15));
            l = (i == len - 1);
            if ((i % ne) == 0 || l) exp_q.push_back({d, s, l});
            send_beat(d, s, l);
            if (i == 0 && lat) check("first_beat_latency", {m00_axis_tvalid, m00_axis_tdata}, {1'b1, d});
            if (i == 0 && mid_n >= 0) dec_factor = 8'(mid_n);
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge s00_axis_aclk);
                #1;
            end
        end
        pkts_sent++;
    endtask

    task automatic drain();
        int t;
        t = 0;
        @(negedge s00_axis_aclk);
        while ((exp_q.size() != 0 || m00_axis_tvalid) && t < 2000) begin
            @(negedge s00_axis_aclk);
            t++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        check("pkt_count", pkt_count, 16'(pkts_sent));
        @(posedge s00_axis_aclk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        #2 s00_axis_aresetn = 1'b0;
        #2;
        check("rst_m_tvalid", m00_axis_tvalid, 0);
        check("rst_m_tdata", {m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast}, 0);
        check("rst_s_tready", s00_axis_tready, 0);
        check("rst_pkt_count", pkt_count, 0);
        repeat (2) @(negedge s00_axis_aclk);
        s00_axis_aresetn = 1'b1;
        #1 check("tready_low_before_first_edge", s00_axis_tready, 0);
        @(posedge s00_axis_aclk);
        #1 check("tready_high_after_first_edge", s00_axis_tready, 1);
        mon_en = 1'b1;

        // N=4, 16 beats, full-rate output
        rdy_mode = 0;
        chk_rdy  = 1'b1;
        send_pkt(4, 16, 0, 0, -1, 0, 1);
        drain();
        chk_rdy = 1'b0;

        // N=3 on two packets, phase restarts per packet
        send_pkt(3, 7, 10, 0, -1, 0, 0);
        send_pkt(3, 6, 20, 0, -1, 0, 0);
        drain();

        // N=2 under periodic backpressure
        rdy_mode = 1;
        send_pkt(2, 40, 100, 0, -1, 0, 0);
        send_pkt(2, 33, 0, 1, -1, 0, 0);
        drain();

        // dec_factor 0 passes everything; mid-packet change applies only to the next packet
        rdy_mode = 0;
        send_pkt(0, 8, 200, 0, -1, 0, 0);
        send_pkt(2, 10, 300, 0, 5, 0, 0);
        send_pkt(5, 11, 400, 0, -1, 0, 0);
        drain();

        // N=1 with single-beat packets
        chk_rdy = 1'b1;
        for (int i = 0; i < 8; i++) send_pkt(1, 1, 32'h500 + 32'(i), 0, -1, 0, 0);
        drain();
        chk_rdy = 1'b0;

        // Randomized packets, factors and backpressure
        rdy_mode = 2;
        for (int i = 0; i < 25; i++)
            send_pkt($urandom_range(0, 6), $urandom_range(1, 20), 0, 1, -1, 1, 0);
        drain();

        // Asynchronous reset with output register and skid both full, mid-packet
        mon_en   = 1'b0;
        rdy_mode = 3;
        dec_factor = 8'd1;
        #10;
        s00_axis_tvalid = 1'b1;
        s00_axis_tdata  = 32'h600;
        t = 0;
        @(negedge s00_axis_aclk);
        while (s00_axis_tready && t < 20) begin
            @(posedge s00_axis_aclk);
            #1 s00_axis_tdata = s00_axis_tdata + 32'd1;
            @(negedge s00_axis_aclk);
            t++;
        end
        check("skid_filled_before_reset", s00_axis_tready, 0);
        #2 s00_axis_aresetn = 1'b0;
        #1;
        check("async_rst_m_tvalid", m00_axis_tvalid, 0);
        check("async_rst_m_tdata", {m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast}, 0);
        check("async_rst_s_tready", s00_axis_tready, 0);
        check("async_rst_pkt_count", pkt_count, 0);
        s00_axis_tvalid = 1'b0;
        exp_q.delete();
        pkts_sent = 0;
        @(negedge s00_axis_aclk);
        s00_axis_aresetn = 1'b1;
        rdy_mode = 0;
        @(posedge s00_axis_aclk);
        #1;
        mon_en = 1'b1;
        send_pkt(3, 5, 32'h700, 0, -1, 0, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fir_decimate.md
Name: fir_decimate

Overview:
- Downstream stage of the 15-tap low-pass FIR in the DSP chain.
- Keeps one of every N filtered samples and drops the rest, reducing the sample rate of the IQ stream before it reaches the DMA/accumulator path.
- AXI-Stream slave in, AXI-Stream master out, with full backpressure through a registered output plus a one-entry skid buffer.
- Packet boundaries (tlast) are always preserved.

Parameters:
- C_S00_AXIS_TDATA_WIDTH, 32, input data width (opaque payload, e.g. packed I/Q).
- C_M00_AXIS_TDATA_WIDTH, 32, output data width; must equal the input width.
- DEC_W, 8, width of the decimation-factor input.

Ports:
- s00_axis_aclk  in  1  single clock for the whole block.
- s00_axis_aresetn  in  1  reset, asynchronous, active-low.
- dec_factor  in  DEC_W  decimation factor N; 0 is treated as 1.
- s00_axis_tdata  in  C_S00_AXIS_TDATA_WIDTH  input sample.
- s00_axis_tstrb  in  C_S00_AXIS_TDATA_WIDTH/8  input byte strobes.
- s00_axis_tvalid  in  1  input valid.
- s00_axis_tlast  in  1  last beat of packet.
- s00_axis_tready  out  1  input ready.
- m00_axis_tdata  out  C_M00_AXIS_TDATA_WIDTH  kept sample.
- m00_axis_tstrb  out  C_M00_AXIS_TDATA_WIDTH/8  strobes of kept sample.
- m00_axis_tvalid  out  1  output valid.
- m00_axis_tlast  out  1  last kept beat of packet.
- m00_axis_tready  in  1  downstream ready.
- pkt_count  out  16  number of output packets completed; wraps at 2^16.

Behaviour:
- Reset is asynchronous and active-low. All state clears immediately on assertion, including mid-packet:
  - m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tdata=0, m00_axis_tstrb=0.
  - s00_axis_tready=0 while reset is asserted; rises to 1 on the first clock after deassertion.
  - phase counter=0, skid buffer empty, pkt_count=0.
- Input acceptance: an input beat is accepted when s00_axis_tvalid && s00_axis_tready.
- Decimation factor:
  - Nlat is latched from dec_factor on the first accepted beat of each packet, i.e. when phase==0 and the previous accepted beat was tlast or this is the first beat after reset.
  - A dec_factor value of 0 latches as 1.
  - Changes to dec_factor mid-packet are ignored until the next packet.
- Keep rule for each accepted beat:
  - Keep if phase==0 OR s00_axis_tlast==1; otherwise drop.
  - Phase update: phase <= (tlast || phase==Nlat-1) ? 0 : phase+1.
  - A tlast beat is always forwarded with m00_axis_tlast=1 and resets phase, even when it falls mid-period.
- N=1: pass-through; every beat is kept.
- Latency: a kept beat appears on m00 the cycle after acceptance when the output register is free. Tdata and tstrb pass unmodified; there is no arithmetic.
- Output stage (registered):
  - Output register plus one skid entry; s00_axis_tready = !skid_valid.
  - Output register empty, or m00_axis_tready=1: a kept beat loads into the output register.
  - Output register full and m00_axis_tready=0: a kept beat loads into the skid entry.
  - When the output transfers and the skid entry is valid, the skid entry moves to the output register in the same cycle.
  - Beat order is always preserved.
- Full-throughput requirement: with constant m00_axis_tready=1, s00_axis_tready stays 1 and the block sustains one input per cycle.
- Dropped beats never stall: tready stays high for dropped beats whenever the skid entry is free.
- AXI-Stream rule: once m00_axis_tvalid rises, m00 tdata/tstrb/tlast hold stable until m00_axis_tready.
- pkt_count increments on each m00 transfer with m00_axis_tlast=1.
- Simultaneous events:
  - Output transfer and new kept beat in the same cycle: the new beat enters the output register with no bubble.
  - Skid full and output transfer in the same cycle: skid moves to output, and s00_axis_tready rises the next cycle.
- States: the control state is {EMPTY, ONE (output register only), TWO (output register + skid)}, derived from the valid bits.

Decomposition:
- Package dsp_pkg:
  - AXIS width localparams.
  - The output-stage state enum {EMPTY, ONE, TWO}.
  - Function clamp_dec(N) that maps 0 to 1.
- Sub-module axis_skid_reg: generic registered AXI-Stream slice with a one-entry skid, carrying the payload {tdata, tstrb, tlast}.
- fir_decimate contains only the phase counter, Nlat latch, keep logic and packet counter.

Test Plan:
- N=4, one packet of 16 beats (0..15), tlast on beat 15, tready=1 -> outputs 0,4,8,12,15; tlast only on 15; pkt_count=1; s00_axis_tready never deasserts.
- N=3, packet of 7 beats (10..16) -> outputs 10,13,16 with tlast on 16. Follow with a second packet 20..25 -> outputs 20,23 then 25 with tlast (25 kept by the tlast rule); phase restarts per packet.
- N=2, continuous input while m00_axis_tready toggles 1,0,0,1 every 4 cycles -> no loss or duplication of kept beats; tdata stable while stalled; s00_axis_tready drops only when the skid entry is full.
- dec_factor=0 -> behaves as N=1 (all beats pass). dec_factor changes from 2 to 5 mid-packet -> factor 2 holds until tlast; 5 applies from the next packet.
- Reset asserted asynchronously mid-packet with output and skid full -> m00_axis_tvalid=0 immediately; the next packet starts at phase 0 with pkt_count=0.
- N=1 with back-to-back packets of length 1 (every beat tlast) -> every beat forwarded with tlast=1; pkt_count increments per beat.
